// File: rtl/auth_pattern_table.sv
// Programmable authorised-signature table: scans one entry per cycle, reports
// the lowest matching index, and locks out requests after repeated misses.
module auth_pattern_table #(
   parameter int FIELD_W        = 8,
   parameter int NUM_ENTRIES    = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   localparam int IDX_W         = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   output logic               cfg_ready,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic               cfg_en,
   input  logic [FIELD_W-1:0] cfg_region,
   input  logic [FIELD_W-1:0] cfg_auth,
   input  logic [FIELD_W-1:0] cfg_expiry,
   input  logic [FIELD_W-1:0] cfg_sig,
   input  logic [FIELD_W-1:0] now,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [FIELD_W-1:0] req_region,
   input  logic [FIELD_W-1:0] req_auth,
   input  logic [FIELD_W-1:0] req_expiry,
   input  logic [FIELD_W-1:0] req_sig,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_match,
   output logic [IDX_W-1:0]   resp_idx,
   output logic               resp_locked,
   output logic               locked
);

   localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
   localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t state, state_next;

   logic [NUM_ENTRIES-1:0] tbl_en;
   logic [FIELD_W-1:0]     tbl_region [NUM_ENTRIES];
   logic [FIELD_W-1:0]     tbl_auth   [NUM_ENTRIES];
   logic [FIELD_W-1:0]     tbl_expiry [NUM_ENTRIES];
   logic [FIELD_W-1:0]     tbl_sig    [NUM_ENTRIES];

   logic [FIELD_W-1:0] r_region, r_auth, r_expiry, r_sig;
   logic [IDX_W-1:0]   scan_idx;
   logic [FAIL_W-1:0]  fail_cnt;
   logic [LOCK_W-1:0]  lock_cnt;

   logic cur_hit, scan_last, scan_done, accept, reject, arm_lock, cfg_wr;

   always_comb begin
      state_next = state;
      cur_hit    = tbl_en[scan_idx]
                   && (r_region == tbl_region[scan_idx])
                   && (r_sig == tbl_sig[scan_idx])
                   && (r_auth >= tbl_auth[scan_idx])
                   && (r_expiry == tbl_expiry[scan_idx])
                   && (now < tbl_expiry[scan_idx]);
      scan_last  = (scan_idx == IDX_W'(NUM_ENTRIES - 1));
      scan_done  = (state == SCAN) && (cur_hit || scan_last);
      accept     = (state == IDLE) && req_valid && (lock_cnt == '0);
      reject     = (state == IDLE) && req_valid && (lock_cnt != '0);
      arm_lock   = scan_done && !cur_hit && (fail_cnt == FAIL_W'(MAX_FAILS - 1));
      cfg_wr     = cfg_we && (state != SCAN)
                   && ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_ENTRIES));
      case (state)
         IDLE:    if (req_valid) state_next = (lock_cnt == '0) ? SCAN : RESP;
         SCAN:    if (cur_hit || scan_last) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   assign req_ready  = (state == IDLE);
   assign cfg_ready  = (state != SCAN);
   assign resp_valid = (state == RESP);
   assign locked     = (lock_cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_en <= '0;
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            tbl_region[i] <= '0;
            tbl_auth[i]   <= '0;
            tbl_expiry[i] <= '0;
            tbl_sig[i]    <= '0;
         end
      end else if (cfg_wr) begin
         tbl_en[cfg_idx]     <= cfg_en;
         tbl_region[cfg_idx] <= cfg_region;
         tbl_auth[cfg_idx]   <= cfg_auth;
         tbl_expiry[cfg_idx] <= cfg_expiry;
         tbl_sig[cfg_idx]    <= cfg_sig;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_region    <= '0;
         r_auth      <= '0;
         r_expiry    <= '0;
         r_sig       <= '0;
         scan_idx    <= '0;
         resp_match  <= 1'b0;
         resp_idx    <= '0;
         resp_locked <= 1'b0;
         fail_cnt    <= '0;
      end else begin
         if (accept) begin
            r_region <= req_region;
            r_auth   <= req_auth;
            r_expiry <= req_expiry;
            r_sig    <= req_sig;
            scan_idx <= '0;
         end else if ((state == SCAN) && !scan_done) begin
            scan_idx <= scan_idx + IDX_W'(1);
         end
         if (reject) begin
            resp_match  <= 1'b0;
            resp_idx    <= '0;
            resp_locked <= 1'b1;
         end else if (scan_done) begin
            resp_match  <= cur_hit;
            resp_idx    <= cur_hit ? scan_idx : '0;
            resp_locked <= 1'b0;
            // A lockout consumes the failure streak, so the count restarts afterwards
            if (cur_hit || arm_lock) fail_cnt <= '0;
            else                     fail_cnt <= fail_cnt + FAIL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 lock_cnt <= '0;
      else if (arm_lock)       lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
      else if (lock_cnt != '0) lock_cnt <= lock_cnt - LOCK_W'(1);
   end

endmodule

// File: doc/auth_pattern_table.md
# auth_pattern_table

Parametrised, programmable successor to the fixed single-pattern signature matcher. It holds a table of `NUM_ENTRIES` authorised signature records, which software programs through a config port. Each request (region, auth level, expiry, signature ID) is scanned against the table one entry per cycle, and the first hit is reported with its index. A consecutive-failure counter triggers a timed lockout that rejects requests without scanning; the block sits between the request decoder and the verdict/logging stage.

## Interface
- `FIELD_W`, 8: width of every record field.
- `NUM_ENTRIES`, 4: table depth, ≥1; `IDX_W = max(1, $clog2(NUM_ENTRIES))`.
- `MAX_FAILS`, 3: consecutive mismatches that trigger lockout, ≥1.
- `LOCKOUT_CYCLES`, 16: lockout duration in clk cycles, ≥1.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_we` in 1: write table entry `cfg_idx`.
- `cfg_ready` out 1: config write accepted this cycle.
- `cfg_idx` in IDX_W: entry index; writes with index ≥ NUM_ENTRIES are ignored.
- `cfg_en` in 1: entry valid bit.
- `cfg_region`, `cfg_auth`, `cfg_expiry`, `cfg_sig` in FIELD_W each: entry contents.
- `now` in FIELD_W: current time stamp.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle.
- `req_region`, `req_auth`, `req_expiry`, `req_sig` in FIELD_W each: request fields.
- `resp_valid` out 1: verdict present.
- `resp_ready` in 1: downstream takes the verdict.
- `resp_match` out 1: hit.
- `resp_idx` out IDX_W: hit entry index; 0 on miss.
- `resp_locked` out 1: request rejected by lockout.
- `locked` out 1: lockout timer active.

## Operation
- Entry k hits when all of the following hold:
  - `en[k]`
  - `req_region==region[k]`
  - `req_sig==sig[k]`
  - `req_auth >= auth[k]` (unsigned)
  - `req_expiry==expiry[k]`
  - `now < expiry[k]` (unsigned; `now` is sampled during the compare cycle)
- FSM states:
  - IDLE: `req_ready=1`.
  - SCAN: `scan_idx` runs 0..NUM_ENTRIES-1.
  - RESP: `resp_valid=1`.
- IDLE + `req_valid`:
  - `lock_cnt==0` → request fields are latched, `scan_idx=0`, go to SCAN.
  - `lock_cnt!=0` → go to RESP with `match=0`, `resp_locked=1`, `idx=0`. `fail_cnt` is not changed.
- SCAN:
  - Hit at `scan_idx` → go to RESP with `match=1` and `idx=scan_idx`. The lowest matching index wins.
  - Miss at the last entry → go to RESP with `match=0`.
- RESP: `resp_*` are held stable until `resp_ready`, then go to IDLE.
- Fail accounting, applied on entry to RESP from SCAN:
  - Hit → `fail_cnt=0`.
  - Miss → `fail_cnt+1`; when this reaches MAX_FAILS, `fail_cnt=0` and `lock_cnt=LOCKOUT_CYCLES`.
- `lock_cnt` decrements every cycle while non-zero, independent of the FSM. `locked = (lock_cnt!=0)`.
- Config:
  - `cfg_ready = (state != SCAN)`.
  - A write with `cfg_we & cfg_ready` updates the entry at the clock edge; it is visible to the next scan.
  - The table never changes mid-scan.
- Reset values:
  - FSM: IDLE.
  - Table: all entries `en=0`, fields 0.
  - Counters: `fail_cnt=0`, `lock_cnt=0`.
  - Outputs: `resp_valid=0`, `resp_match=0`, `resp_idx=0`, `resp_locked=0`, `locked=0`, `req_ready=1`, `cfg_ready=1`.
- Reset mid-scan or mid-response: the transaction is dropped and no response is produced.

## Timing
- Request accepted at edge T (`req_valid & req_ready`). Entry k is compared during cycle T+1+k.
- Hit at entry k → `resp_valid` from cycle T+2+k.
- Miss → `resp_valid` from cycle T+1+NUM_ENTRIES.
- Locked reject → `resp_valid` from cycle T+1.
- `req_ready` drops the cycle after acceptance. It returns the cycle after the `resp_valid & resp_ready` handshake; there are no back-to-back accepts.
- A lockout armed at the edge that enters RESP makes `locked` rise in the same cycle `resp_valid` rises. `locked` falls exactly LOCKOUT_CYCLES cycles later.
- Simultaneous config write and request accept in IDLE: the write lands at the same edge, before the scan's first compare, so the scan sees the new data.

## Test plan
- Program entry 2 = {0x0A, 0x01, 0x10, 0xF3} with `en=1`, `now=0x05`; request {0x0A, 0x02, 0x10, 0xF3} → `resp_match=1`, `resp_idx=2`, `resp_valid` 4 cycles after accept.
- Same setup with `now=0x10` → miss (expiry reached). With `req_auth=0x00` → miss (auth below minimum). Miss `resp_valid` 5 cycles after accept (NUM_ENTRIES=4).
- Entries 1 and 3 identical and valid; matching request → `resp_idx=1`.
- Three consecutive misses → `locked=1` together with the third verdict. The next request gets `resp_locked=1`, `match=0` one cycle after accept, even if it would match. `locked` clears after 16 cycles, and a matching request then hits.
- Hold `resp_ready=0` for 5 cycles → `resp_*` stable and `req_ready=0` throughout. A `cfg_we` during SCAN → `cfg_ready=0` and the table is unchanged.
- Assert `rst` mid-SCAN → all outputs at reset values immediately, no response, table cleared (a subsequent matching request misses).
